cook_sequencer: RTL
===================

COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 clock  in  1  system clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset; asynchronous, active-low.
REQ-003 tick  in  1  one-cycle pulse at 1 s cadence from the prescaler.
REQ-004 startn, stopn, clearn  in  1 each  active-low button levels, already synchronized; block acts on the falling edge only.
REQ-005 door_closed  in  1  high = door closed.
REQ-006 power_level  in  4  cook power 1..10; 0 and values >10 are treated as 10.
REQ-007 time_zero  in  1  timer datapath reports 0:00 remaining.
REQ-008 key_en  out  1  keypad entry permitted; high only in IDLE.
REQ-009 count_en  out  1  one-cycle decrement pulse to the timer datapath.
REQ-010 time_clear  out  1  one-cycle clear pulse to the timer datapath.
REQ-011 mag_on  out  1  magnetron enable.
REQ-012 beep  out  1  completion tone enable.
REQ-013 state  out  2  current state encoding, IDLE=0, COOK=1, PAUSE=2, DONE=3.

Function
REQ-014 Button event = registered previous level 1 and current level 0, producing one event per press; a held button yields no further events.
REQ-015 IDLE: start event with door_closed=1 and time_zero=0 -> COOK, latching the clamped power_level and clearing phase to 0. A start event with the door open or time_zero=1 is ignored.
REQ-016 IDLE: clear event -> time_clear pulse next cycle; remain IDLE.
REQ-017 COOK event priority, highest first: door_closed=0 -> PAUSE; stop event -> PAUSE; time_zero=1 -> DONE; tick -> count_en pulse plus phase update.
REQ-018 Phase is a 4-bit counter, 0..9, incremented on each COOK tick, wrapping 9->0.
REQ-019 mag_on = (state==COOK) AND door_closed AND (phase < latched power). The door_closed term is combinational, so the magnetron drops in the same cycle the door opens.
REQ-020 count_en is asserted the cycle after an accepted COOK tick, one cycle wide. No count_en is issued in any other state, or when time_zero=1.
REQ-021 PAUSE: start event with door_closed=1 -> COOK, with phase and latched power preserved.
REQ-022 PAUSE: stop or clear event -> IDLE plus time_clear pulse. A start event with the door open is ignored.
REQ-023 DONE: beep=1 on entry; beep counter counts 3 ticks, then -> IDLE with beep=0.
REQ-024 DONE: any start, stop or clear event, or door_closed=0, -> IDLE immediately with beep=0.
REQ-025 Simultaneous start and stop events: stop wins in every state.
REQ-026 Events arriving in a state with no transition for them are discarded, not queued.

Reset
REQ-027 resetn=0 forces state=IDLE, phase=0, latched power=10 and beep counter=0.
REQ-028 During and after reset, until the first qualifying event: count_en=0, time_clear=0, mag_on=0, beep=0, key_en=1.
REQ-029 Button history registers reset to 1 (released), so no spurious event after reset release.
REQ-030 Reset asserted mid-COOK drops mag_on within the same cycle (asynchronous).

Structure
REQ-031 Package microwave_pkg holds the state encoding, POWER_MAX=10, PHASE_WRAP=10 and BEEP_TICKS=3.
REQ-032 One sub-module, btn_edge (falling-edge detector with reset-to-1 history), instantiated once each for startn, stopn and clearn.
REQ-033 Timer arithmetic and 7-segment decoding are out of scope; this block only sequences them.

Verification
REQ-034 Power 10, door closed, time_zero=0, start press, 5 ticks then time_zero=1 -> mag_on high throughout COOK, 5 count_en pulses, then DONE, beep for 3 ticks, then IDLE.
REQ-035 Power 3, 12 ticks in COOK -> mag_on high in phases 0-2 only; pattern repeats after phase 9 wraps to 0.
REQ-036 Door opened mid-COOK -> mag_on=0 the same cycle, state=PAUSE, no count_en. Door closed, then start -> COOK resumes with phase unchanged.
REQ-037 Start and stop pressed in the same cycle while in IDLE -> remain IDLE. Stop in PAUSE -> IDLE plus one time_clear pulse.
REQ-038 Start held low for 20 cycles -> exactly one transition. resetn pulsed low during COOK -> all outputs at reset values immediately, key_en=1.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook sequencer: state encoding,
// power/phase/beep limits and the power clamp helper.
package microwave_pkg;

  localparam int unsigned POWER_MAX  = 10;
  localparam int unsigned PHASE_WRAP = 10;
  localparam int unsigned BEEP_TICKS = 3;
  localparam int unsigned POWER_W    = 4;
  localparam int unsigned PHASE_W    = 4;
  localparam int unsigned BEEP_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Out-of-range settings (0 or above the maximum) run at full power.
  function automatic logic [POWER_W-1:0] clamp_power(input logic [POWER_W-1:0] p);
    if (p == '0 || p > POWER_W'(POWER_MAX)) begin
      return POWER_W'(POWER_MAX);
    end
    return p;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Falling-edge detector for an active-low, pre-synchronized button level.
// Ports: clock, resetn (async active-low), level (button level),
//        fall_c (one-cycle press event, combinational from history).
module btn_edge (
  input  logic clock,
  input  logic resetn,
  input  logic level,
  output logic fall_c
);

  logic prev;

  // History resets to released so a reset release never looks like a press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  assign fall_c = prev & ~level;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: runs IDLE/COOK/PAUSE/DONE, gates the magnetron
// by a 10-phase duty cycle and pulses the timer datapath.
// Ports: clock, resetn (async active-low), tick (1 s pulse), startn/stopn/
//        clearn (active-low buttons), door_closed, power_level[3:0],
//        time_zero | key_en, count_en, time_clear, mag_on, beep, state[1:0].
module cook_sequencer
  import microwave_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               tick,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic [POWER_W-1:0] power_level,
  input  logic               time_zero,
  output logic               key_en,
  output logic               count_en,
  output logic               time_clear,
  output logic               mag_on,
  output logic               beep,
  output logic [1:0]         state
);

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [POWER_W-1:0]  power_q, power_d;
  logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
  logic                count_en_d, time_clear_d;
  logic                start_ev, stop_ev, clear_ev;

  btn_edge u_start (.clock(clock), .resetn(resetn), .level(startn), .fall_c(start_ev));
  btn_edge u_stop  (.clock(clock), .resetn(resetn), .level(stopn),  .fall_c(stop_ev));
  btn_edge u_clear (.clock(clock), .resetn(resetn), .level(clearn), .fall_c(clear_ev));

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      power_q    <= POWER_W'(POWER_MAX);
      beep_cnt_q <= '0;
      count_en   <= 1'b0;
      time_clear <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      power_q    <= power_d;
      beep_cnt_q <= beep_cnt_d;
      count_en   <= count_en_d;
      time_clear <= time_clear_d;
    end
  end

  // Next-state logic; stop always outranks start.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    power_d      = power_q;
    beep_cnt_d   = '0;
    count_en_d   = 1'b0;
    time_clear_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_ev) begin
          time_clear_d = 1'b1;
        end else if (start_ev && !stop_ev && door_closed && !time_zero) begin
          state_d = ST_COOK;
          power_d = clamp_power(power_level);
          phase_d = '0;
        end
      end
      ST_COOK: begin
        if (!door_closed || stop_ev) begin
          state_d = ST_PAUSE;
        end else if (time_zero) begin
          state_d = ST_DONE;
        end else if (tick) begin
          count_en_d = 1'b1;
          phase_d    = (phase_q == PHASE_W'(PHASE_WRAP - 1)) ? '0 : phase_q + PHASE_W'(1);
        end
      end
      ST_PAUSE: begin
        if (stop_ev || clear_ev) begin
          state_d      = ST_IDLE;
          time_clear_d = 1'b1;
        end else if (start_ev && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        beep_cnt_d = beep_cnt_q;
        if (start_ev || stop_ev || clear_ev || !door_closed) begin
          state_d    = ST_IDLE;
          beep_cnt_d = '0;
        end else if (tick) begin
          if (beep_cnt_q == BEEP_W'(BEEP_TICKS - 1)) begin
            state_d    = ST_IDLE;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + BEEP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Door term is live so the magnetron drops in the cycle the door opens.
  assign mag_on = (state_q == ST_COOK) && door_closed && (phase_q < power_q);
  assign key_en = (state_q == ST_IDLE);
  assign beep   = (state_q == ST_DONE);
  assign state  = state_q;

endmodule
